// File: rtl/keypad_scanner.sv
// Column scanner and row debouncer for a 4x4 active-low keypad.
// Presents a stable row pattern and column index to the downstream hex encoder.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] col_drive,
  output logic [1:0] counter,
  output logic [3:0] keyboard,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_dwell;
  logic [SW-1:0] r_stable;
  logic [3:0]    r_cand;
  logic [3:0]    r_sync1;
  logic [3:0]    r_srow;
  logic [3:0]    r_col_drive;
  logic [1:0]    r_counter;
  logic [3:0]    r_keyboard;
  logic          r_accept;
  logic          r_key_valid;
  logic          r_key_held;

  logic       w_single;
  logic [3:0] w_next_col;

  assign w_single   = (r_srow == 4'b1110) || (r_srow == 4'b1101) ||
                      (r_srow == 4'b1011) || (r_srow == 4'b0111);
  assign w_next_col = {r_col_drive[2:0], r_col_drive[3]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 4'b1111;
      r_srow  <= 4'b1111;
    end else begin
      r_sync1 <= rows;
      r_srow  <= r_sync1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_SCAN;
      r_dwell     <= '0;
      r_stable    <= '0;
      r_cand      <= 4'b1111;
      r_col_drive <= 4'b1110;
      r_counter   <= 2'd0;
      r_keyboard  <= 4'b1111;
      r_accept    <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      // The pulse trails acceptance by one cycle so it lines up with the encoder's registered hex_out.
      r_accept    <= 1'b0;
      r_key_valid <= r_accept;
      case (r_state)
        S_SCAN: begin
          if (r_dwell == DWELL_LAST) begin
            if (w_single) begin
              r_cand   <= r_srow;
              r_stable <= '0;
              r_state  <= S_DEBOUNCE;
            end else begin
              r_dwell     <= '0;
              r_col_drive <= w_next_col;
              r_counter   <= r_counter + 2'd1;
            end
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        S_DEBOUNCE: begin
          if (r_srow == r_cand) begin
            if (r_stable == STABLE_LAST) begin
              r_keyboard <= r_cand;
              r_key_held <= 1'b1;
              r_accept   <= 1'b1;
              r_state    <= S_HOLD;
            end else begin
              r_stable <= r_stable + SW'(1);
            end
          end else begin
            r_dwell     <= '0;
            r_col_drive <= w_next_col;
            r_counter   <= r_counter + 2'd1;
            r_state     <= S_SCAN;
          end
        end
        S_HOLD: begin
          if (r_srow != r_cand) begin
            r_stable <= '0;
            r_state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (r_srow == 4'b1111) begin
            if (r_stable == STABLE_LAST) begin
              r_keyboard  <= 4'b1111;
              r_key_held  <= 1'b0;
              r_dwell     <= '0;
              r_col_drive <= w_next_col;
              r_counter   <= r_counter + 2'd1;
              r_state     <= S_SCAN;
            end else begin
              r_stable <= r_stable + SW'(1);
            end
          end else if (r_srow == r_cand) begin
            r_state <= S_HOLD;
          end else begin
            r_stable <= '0;
          end
        end
        default: r_state <= S_SCAN;
      endcase
    end
  end

  assign col_drive = r_col_drive;
  assign counter   = r_counter;
  assign keyboard  = r_keyboard;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad model, stand-in registered encoder,
// directed scan/press/glitch/bounce/reset sequences and randomized press episodes.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  // Worst-case press-to-pulse time: up to a full scan to reach the column, plus sync, debounce and pulse.
  localparam int MIN_ACCEPT = 5 * SCAN_DIV + 2 + DEBOUNCE + 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] col_drive;
  logic [1:0] counter;
  logic [3:0] keyboard;
  logic       key_valid;
  logic       key_held;
  logic [3:0] hex_out;
  logic [15:0] pressed = '0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] cnt;
    logic [3:0] col;
    int         cycles;
  } scan_vec_t;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock    (clock),
    .reset    (reset),
    .rows     (rows),
    .col_drive(col_drive),
    .counter  (counter),
    .keyboard (keyboard),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clock = ~clock;

  // Keypad: a pressed key at (c, r) pulls row r low only while column c is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && (col_drive[c] == 1'b0)) rows[r] = 1'b0;
  end

  // Stand-in encoder: keys numbered row-major starting at 1, registered like the real encoder.
  function automatic logic [3:0] key_code(input logic [3:0] kb, input logic [1:0] col);
    logic [3:0] code;
    logic [3:0] pat;
    code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      pat = ~(4'b0001 << r);
      if (kb == pat) code = 4'((4 * r + int'(col) + 1) % 16);
    end
    return code;
  endfunction

  always_ff @(posedge clock) hex_out <= key_code(keyboard, counter);

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_counter(input logic [1:0] val);
    int n = 0;
    while (counter !== val && n < 64) begin
      step();
      n++;
    end
    check("wait_counter", 32'(counter), 32'(val));
  endtask

  task automatic wait_held(input logic val);
    int n = 0;
    while (key_held !== val && n < 64) begin
      step();
      n++;
    end
    check("wait_held", 32'(key_held), 32'(val));
  endtask

  task automatic check_reset_values(input string name);
    check(name, {16'h0, col_drive, 2'b0, counter, keyboard, 2'b0, key_valid, key_held},
          {16'h0, 4'b1110, 2'b0, 2'd0, 4'b1111, 2'b0, 1'b0, 1'b0});
  endtask

  initial begin
    scan_vec_t  scan_tbl[5];
    int         pulses;
    int         changes;
    logic [1:0] prev_cnt;
    logic [3:0] exp_kb;
    int         c, r, dur;
    bit         long_press;

    scan_tbl[0] = '{2'd0, 4'b1110, SCAN_DIV};
    scan_tbl[1] = '{2'd1, 4'b1101, SCAN_DIV};
    scan_tbl[2] = '{2'd2, 4'b1011, SCAN_DIV};
    scan_tbl[3] = '{2'd3, 4'b0111, SCAN_DIV};
    scan_tbl[4] = '{2'd0, 4'b1110, SCAN_DIV};

    // Reset, then idle scanning
    step(2);
    reset = 1'b0;
    check_reset_values("reset_values");
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < scan_tbl[i].cycles; k++) begin
        check("scan_counter", 32'(counter), 32'(scan_tbl[i].cnt));
        check("scan_col_drive", 32'(col_drive), 32'(scan_tbl[i].col));
        check("scan_keyboard", 32'(keyboard), 32'(4'b1111));
        check("scan_key_valid", 32'(key_valid), 32'(1'b0));
        step();
      end
    end

    // Press column 1 / row 2 for 20 cycles
    check("press_start_col", 32'(counter), 32'(2'd1));
    pressed[1*4+2] = 1'b1;
    pulses = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (key_valid) begin
        pulses++;
        check("press_hex_out", 32'(hex_out), 32'(4'hA));
        check("press_kb_at_pulse", 32'(keyboard), 32'(4'b1011));
      end
    end
    check("press_pulses", 32'(pulses), 32'(1));
    check("press_counter", 32'(counter), 32'(2'd1));
    check("press_keyboard", 32'(keyboard), 32'(4'b1011));
    check("press_key_held", 32'(key_held), 32'(1'b1));

    // Bounce: release for 2 cycles, re-press
    pressed[1*4+2] = 1'b0;
    step(2);
    pressed[1*4+2] = 1'b1;
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      step();
      if (key_valid) pulses++;
      check("bounce_key_held", 32'(key_held), 32'(1'b1));
    end
    check("bounce_pulses", 32'(pulses), 32'(0));
    check("bounce_keyboard", 32'(keyboard), 32'(4'b1011));

    // Clean release: two sync stages, one cycle to enter release, DEBOUNCE confirmations
    pressed[1*4+2] = 1'b0;
    step(5);
    check("release_still_held", 32'(key_held), 32'(1'b1));
    step();
    check("release_key_held", 32'(key_held), 32'(1'b0));
    check("release_keyboard", 32'(keyboard), 32'(4'b1111));
    check("release_counter", 32'(counter), 32'(2'd2));
    check("release_col_drive", 32'(col_drive), 32'(4'b1011));

    // Glitch on column 3 / row 0 for 2 cycles
    wait_counter(2'd3);
    pressed[3*4+0] = 1'b1;
    step(2);
    pressed[3*4+0] = 1'b0;
    step(2);
    check("glitch_frozen_counter", 32'(counter), 32'(2'd3));
    step();
    check("glitch_resume_counter", 32'(counter), 32'(2'd0));
    pulses = 0;
    for (int t = 0; t < 12; t++) begin
      step();
      if (key_valid) pulses++;
    end
    check("glitch_pulses", 32'(pulses), 32'(0));
    check("glitch_keyboard", 32'(keyboard), 32'(4'b1111));

    // Two rows low on column 0
    wait_counter(2'd0);
    while (col_drive !== 4'b1110) step();
    pressed[0*4+1] = 1'b1;
    pressed[0*4+2] = 1'b1;
    pulses   = 0;
    changes  = 0;
    prev_cnt = counter;
    for (int t = 0; t < 8 * SCAN_DIV; t++) begin
      step();
      if (key_valid) pulses++;
      if (counter != prev_cnt) changes++;
      prev_cnt = counter;
    end
    check("multi_pulses", 32'(pulses), 32'(0));
    check("multi_key_held", 32'(key_held), 32'(1'b0));
    check("multi_keyboard", 32'(keyboard), 32'(4'b1111));
    pressed = '0;
    step(2 * SCAN_DIV);

    // Randomized press episodes; a second key in another column is ignored while held
    for (int ep = 0; ep < 12; ep++) begin
      c          = $urandom_range(0, 3);
      r          = $urandom_range(0, 3);
      long_press = ($urandom_range(0, 2) != 0);
      dur        = long_press ? $urandom_range(MIN_ACCEPT + 10, MIN_ACCEPT + 30) : $urandom_range(1, 2);
      exp_kb     = ~(4'b0001 << r);
      step($urandom_range(0, 7));
      pressed[c*4+r] = 1'b1;
      pulses = 0;
      for (int t = 0; t < dur; t++) begin
        step();
        if (t == MIN_ACCEPT && $urandom_range(0, 1) == 1)
          pressed[((c + 1) % 4) * 4 + int'($urandom_range(0, 3))] = 1'b1;
        if (key_valid) begin
          pulses++;
          check("rand_counter", 32'(counter), 32'(c));
          check("rand_keyboard", 32'(keyboard), 32'(exp_kb));
          check("rand_hex_out", 32'(hex_out), 32'(key_code(exp_kb, 2'(c))));
          check("rand_held_at_pulse", 32'(key_held), 32'(1'b1));
        end
      end
      pressed = '0;
      if (long_press) begin
        check("rand_kb_before_release", 32'(keyboard), 32'(exp_kb));
        step(5);
        check("rand_release_held", 32'(key_held), 32'(1'b1));
        step();
        check("rand_release_done", 32'(key_held), 32'(1'b0));
        check("rand_release_counter", 32'(counter), 32'((c + 1) % 4));
      end else begin
        for (int t = 0; t < 8; t++) begin
          step();
          if (key_valid) pulses++;
        end
        check("rand_short_held", 32'(key_held), 32'(1'b0));
      end
      check("rand_pulses", 32'(pulses), 32'(long_press ? 1 : 0));
      check("rand_idle_keyboard", 32'(keyboard), 32'(4'b1111));
    end

    // Reset while in HOLD
    pressed[2*4+3] = 1'b1;
    wait_held(1'b1);
    reset   = 1'b1;
    pressed = '0;
    step();
    reset = 1'b0;
    check_reset_values("hold_reset_values");
    step(SCAN_DIV - 1);
    check("post_reset_counter0", 32'(counter), 32'(2'd0));
    step();
    check("post_reset_counter1", 32'(counter), 32'(2'd1));
    check("post_reset_col_drive", 32'(col_drive), 32'(4'b1101));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
